// File: rtl/agnus_sprite_dma_seq_pkg.sv
// Shared definitions for the sprite DMA sequencer.
// Contents:
//   - Register addresses as seen on the [8:1] register bus (byte address >> 1).
//   - Slot spacing between sprites and the offset of the B slot inside a sprite's slot pair.
//   - Per-sprite vertical state encoding.
//   - spr_reg(): builds a per-sprite register address from a base, a stride and an offset.
package agnus_sprite_dma_seq_pkg;

    localparam int unsigned NUM_SPRITES = 8;

    // Register bases on the [8:1] bus: SPRPT = 0x120, SPRPOS = 0x140.
    localparam logic [7:0] SPRPT_BASE  = 8'h90;
    localparam logic [7:0] SPRPOS_BASE = 8'hA0;
    localparam logic [7:0] REG_NONE    = 8'hFF;

    // Each sprite owns 2 pointer words and 4 shifter registers.
    localparam int unsigned PT_STRIDE  = 2;
    localparam int unsigned POS_STRIDE = 4;
    localparam int unsigned OFS_PTH    = 0;
    localparam int unsigned OFS_PTL    = 1;
    localparam int unsigned OFS_POS    = 0;
    localparam int unsigned OFS_CTL    = 1;
    localparam int unsigned OFS_DATA   = 2;
    localparam int unsigned OFS_DATB   = 3;

    // Slot layout in hpos: sprite n word A at base+4n, word B two colour clocks later.
    localparam int unsigned SLOT_STRIDE = 4;
    localparam int unsigned SLOT_B_OFS  = 2;

    typedef enum logic [1:0] {
        SPR_IDLE     = 2'd0,
        SPR_FETCH_PC = 2'd1,
        SPR_WAIT     = 2'd2,
        SPR_ACTIVE   = 2'd3
    } spr_state_e;

    function automatic logic [7:0] spr_reg(input logic [7:0] base, input int unsigned stride,
                                           input int unsigned idx, input int unsigned ofs);
        return base + 8'(stride * idx + ofs);
    endfunction

endpackage

// File: rtl/agnus_sprite_dma_channel.sv
// One hardware sprite's DMA channel: vertical state, chip pointer, vstart/vstop and slot decode.
// Ports:
//   clk, reset         28MHz clock, synchronous active-high reset
//   clk7_en            7MHz enable; state only moves when high
//   hpos, vpos         beam counters
//   vbl_end            first line after vertical blank
//   spr_dma_en         sprite DMA enable; low freezes everything DMA-driven
//   reg_address_in     CPU register address [8:1] (pointer writes)
//   data_in            CPU write data / DMA read data
//   dma_ack            bus grant for the current slot
//   req                this channel requests the current slot
//   addr               pointer while requesting, zero otherwise
//   strb_reg           Denise register strobe for an acked fetch, 8'hFF otherwise
module agnus_sprite_dma_channel
    import agnus_sprite_dma_seq_pkg::*;
#(
    parameter int unsigned IDX       = 0,
    parameter logic [8:0]  SLOT_BASE = 9'h015,
    parameter int unsigned PTR_W     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic [8:0]       hpos,
    input  logic [8:0]       vpos,
    input  logic             vbl_end,
    input  logic             spr_dma_en,
    input  logic [7:0]       reg_address_in,
    input  logic [15:0]      data_in,
    input  logic             dma_ack,
    output logic             req,
    output logic [PTR_W-1:0] addr,
    output logic [7:0]       strb_reg
);

    localparam logic [8:0] SLOT_A   = SLOT_BASE + 9'(SLOT_STRIDE * IDX);
    localparam logic [8:0] SLOT_B   = SLOT_A + 9'(SLOT_B_OFS);
    localparam logic [7:0] PTH_REG  = spr_reg(SPRPT_BASE, PT_STRIDE, IDX, OFS_PTH);
    localparam logic [7:0] PTL_REG  = spr_reg(SPRPT_BASE, PT_STRIDE, IDX, OFS_PTL);
    localparam logic [7:0] POS_REG  = spr_reg(SPRPOS_BASE, POS_STRIDE, IDX, OFS_POS);
    localparam logic [7:0] CTL_REG  = spr_reg(SPRPOS_BASE, POS_STRIDE, IDX, OFS_CTL);
    localparam logic [7:0] DATA_REG = spr_reg(SPRPOS_BASE, POS_STRIDE, IDX, OFS_DATA);
    localparam logic [7:0] DATB_REG = spr_reg(SPRPOS_BASE, POS_STRIDE, IDX, OFS_DATB);

    spr_state_e       state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [8:0]       vstart_r;
    logic [8:0]       vstop_r;
    logic             slot_a_s;
    logic             slot_b_s;
    logic             req_s;
    logic             take_s;
    logic [7:0]       slot_reg_s;
    logic             unused_data_s;

    assign slot_a_s = (hpos == SLOT_A);
    assign slot_b_s = (hpos == SLOT_B);
    assign req_s    = spr_dma_en && (slot_a_s || slot_b_s) &&
                      ((state_r == SPR_FETCH_PC) || (state_r == SPR_ACTIVE));
    // A fetch completes only on a 7MHz edge with grant, never while reset is held.
    assign take_s   = req_s && dma_ack && clk7_en && !reset;

    assign req      = req_s;
    assign addr     = req_s ? ptr_r : '0;
    assign strb_reg = take_s ? slot_reg_s : REG_NONE;

    // Not every bit of the shared bus feeds this channel.
    assign unused_data_s = ^data_in;

    // Destination register for the word fetched in the current slot.
    always_comb begin
        slot_reg_s = REG_NONE;
        case (state_r)
            SPR_FETCH_PC: begin
                if (slot_a_s) slot_reg_s = POS_REG;
                else          slot_reg_s = CTL_REG;
            end
            SPR_ACTIVE: begin
                // DATB first; DATA last arms the shifter.
                if (slot_a_s) slot_reg_s = DATB_REG;
                else          slot_reg_s = DATA_REG;
            end
            default: slot_reg_s = REG_NONE;
        endcase
    end

    // Chip pointer: CPU writes take precedence over the post-fetch increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (clk7_en) begin
            if (reg_address_in == PTH_REG) begin
                ptr_r[PTR_W-1:15] <= data_in[PTR_W-16:0];
            end else if (reg_address_in == PTL_REG) begin
                ptr_r[14:0] <= data_in[15:1];
            end else if (take_s) begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

    // Vertical state and POS/CTL capture; frozen while sprite DMA is off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= SPR_IDLE;
            vstart_r <= 9'd0;
            vstop_r  <= 9'd0;
        end else if (clk7_en && spr_dma_en) begin
            if (hpos == 9'd0) begin
                if (vbl_end) begin
                    state_r <= SPR_FETCH_PC;
                end else begin
                    case (state_r)
                        SPR_WAIT: begin
                            // Zero-height sprite skips ACTIVE and reloads control words at once.
                            if (vpos == vstart_r)
                                state_r <= (vstart_r == vstop_r) ? SPR_FETCH_PC : SPR_ACTIVE;
                        end
                        SPR_ACTIVE: begin
                            if (vpos == vstop_r) state_r <= SPR_FETCH_PC;
                        end
                        default: state_r <= state_r;
                    endcase
                end
            end else if (take_s && (state_r == SPR_FETCH_PC)) begin
                if (slot_a_s) begin
                    vstart_r[7:0] <= data_in[15:8];
                end else begin
                    vstop_r[7:0] <= data_in[15:8];
                    vstart_r[8]  <= data_in[2];
                    vstop_r[8]   <= data_in[1];
                    state_r      <= SPR_WAIT;
                end
            end
        end
    end

endmodule

// File: rtl/agnus_sprite_dma_seq.sv
// Per-line sprite DMA scheduler for the eight hardware sprites.
// Ports:
//   clk, reset          28MHz clock, synchronous active-high reset
//   clk7_en             7MHz enable
//   hpos, vpos          beam counters
//   vbl_end             first line after vertical blank
//   spr_dma_en          DMAEN & SPREN
//   reg_address_in      CPU register address [8:1]
//   data_in             CPU write data / DMA read data
//   dma_ack             bus granted for the current slot
//   dma_req             fetch request for the current slot
//   dma_addr            word address of the request (zero when no request)
//   reg_address_out     Denise register strobe [8:1], 8'hFF when none
module agnus_sprite_dma_seq
    import agnus_sprite_dma_seq_pkg::*;
#(
    parameter logic [8:0]  SLOT_BASE = 9'h015,
    parameter int unsigned PTR_W     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic [8:0]       hpos,
    input  logic [8:0]       vpos,
    input  logic             vbl_end,
    input  logic             spr_dma_en,
    input  logic [7:0]       reg_address_in,
    input  logic [15:0]      data_in,
    input  logic             dma_ack,
    output logic             dma_req,
    output logic [PTR_W-1:0] dma_addr,
    output logic [7:0]       reg_address_out
);

    logic [NUM_SPRITES-1:0] ch_req_s;
    logic [PTR_W-1:0]       ch_addr_s [NUM_SPRITES];
    logic [7:0]             ch_strb_s [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
        agnus_sprite_dma_channel #(
            .IDX       (g),
            .SLOT_BASE (SLOT_BASE),
            .PTR_W     (PTR_W)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .clk7_en        (clk7_en),
            .hpos           (hpos),
            .vpos           (vpos),
            .vbl_end        (vbl_end),
            .spr_dma_en     (spr_dma_en),
            .reg_address_in (reg_address_in),
            .data_in        (data_in),
            .dma_ack        (dma_ack),
            .req            (ch_req_s[g]),
            .addr           (ch_addr_s[g]),
            .strb_reg       (ch_strb_s[g])
        );
    end

    // Slots never overlap, so at most one channel is active: idle channels drive
    // zero addresses (neutral for OR) and 8'hFF strobes (neutral for AND).
    always_comb begin
        dma_req         = 1'b0;
        dma_addr        = '0;
        reg_address_out = REG_NONE;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dma_req         = dma_req | ch_req_s[i];
            dma_addr        = dma_addr | ch_addr_s[i];
            reg_address_out = reg_address_out & ch_strb_s[i];
        end
    end

endmodule

// File: tb/tb_agnus_sprite_dma_seq.sv
// Directed bench for agnus_sprite_dma_seq. Expected slot events are queued per line and
// popped as the beam reaches them; every other cycle must be idle.
module tb_agnus_sprite_dma_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        vbl_end;
    logic        spr_dma_en;
    logic [7:0]  reg_address_in;
    logic [15:0] data_in;
    logic        dma_ack;
    logic        dma_req;
    logic [19:0] dma_addr;
    logic [7:0]  reg_address_out;

    always #5 clk = ~clk;

    agnus_sprite_dma_seq #(.SLOT_BASE(9'h015), .PTR_W(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .hpos           (hpos),
        .vpos           (vpos),
        .vbl_end        (vbl_end),
        .spr_dma_en     (spr_dma_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .dma_ack        (dma_ack),
        .dma_req        (dma_req),
        .dma_addr       (dma_addr),
        .reg_address_out(reg_address_out)
    );

    localparam logic [8:0] SB       = 9'h015;
    localparam int         LINE_LEN = 54;      // covers sprite 7 slot B at 0x33
    localparam logic [7:0] NONE     = 8'hFF;
    localparam logic [7:0] PTH0     = 8'h90;   // 0x120 >> 1
    localparam logic [7:0] PTL0     = 8'h91;   // 0x122 >> 1
    localparam logic [7:0] POS0     = 8'hA0;   // 0x140 >> 1

    typedef struct {
        logic [8:0]  h;
        logic        ack;
        logic [15:0] data;
        logic [7:0]  cpu;
        logic        req;
        logic [19:0] addr;
        logic [7:0]  strb;
    } ev_t;

    ev_t         ev_q[$];
    logic [19:0] ptr_m [8];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic r, input logic [19:0] a, input logic [7:0] s);
        vectors++;
        assert ({dma_req, dma_addr, reg_address_out} === {r, a, s}) else begin
            miscompares++;
            $error("FAIL %s h=%h v=%h: got req=%b addr=%h reg=%h, expected req=%b addr=%h reg=%h",
                   tag, hpos, vpos, dma_req, dma_addr, reg_address_out, r, a, s);
        end
    endtask

    task automatic push_ev(input logic [8:0] h, input logic ack, input logic [15:0] data,
                           input logic [7:0] cpu, input logic [19:0] addr, input logic [7:0] strb);
        ev_t e;
        e = '{h: h, ack: ack, data: data, cpu: cpu, req: 1'b1, addr: addr, strb: strb};
        ev_q.push_back(e);
    endtask

    // POS/CTL pair for sprite n; unacked words give no strobe and no pointer step.
    task automatic push_pc(input int n, input logic ack_a, input logic ack_b,
                           input logic [15:0] pos, input logic [15:0] ctl);
        logic [8:0] sa;
        sa = SB + 9'(4 * n);
        push_ev(sa, ack_a, pos, NONE, ptr_m[n], ack_a ? POS0 + 8'(4 * n) : NONE);
        if (ack_a) ptr_m[n] = ptr_m[n] + 20'd1;
        push_ev(sa + 9'd2, ack_b, ctl, NONE, ptr_m[n], ack_b ? POS0 + 8'(4 * n + 1) : NONE);
        if (ack_b) ptr_m[n] = ptr_m[n] + 20'd1;
    endtask

    // DATB in slot A, DATA in slot B.
    task automatic push_data(input int n);
        logic [8:0] sa;
        sa = SB + 9'(4 * n);
        push_ev(sa, 1'b1, 16'hA5A5, NONE, ptr_m[n], POS0 + 8'(4 * n + 3));
        ptr_m[n] = ptr_m[n] + 20'd1;
        push_ev(sa + 9'd2, 1'b1, 16'h5A5A, NONE, ptr_m[n], POS0 + 8'(4 * n + 2));
        ptr_m[n] = ptr_m[n] + 20'd1;
    endtask

    task automatic run_line(input logic [8:0] v, input logic vbl, input string tag);
        ev_t e;
        for (int h = 0; h < LINE_LEN; h++) begin
            e = '{h: 9'(h), ack: 1'b0, data: 16'h0000, cpu: NONE, req: 1'b0, addr: 20'h0, strb: NONE};
            if (ev_q.size() > 0 && ev_q[0].h == 9'(h)) e = ev_q.pop_front();
            hpos           = 9'(h);
            vpos           = v;
            vbl_end        = vbl;
            dma_ack        = e.ack;
            data_in        = e.data;
            reg_address_in = e.cpu;
            #1;
            check(tag, e.req, e.addr, e.strb);
            @(negedge clk);
        end
        dma_ack        = 1'b0;
        reg_address_in = NONE;
        data_in        = 16'h0000;
        vbl_end        = 1'b0;
        vectors++;
        assert (ev_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s_events: %0d expected slot events left, expected 0", tag, ev_q.size());
        end
        ev_q.delete();
    endtask

    task automatic cpu_wr(input logic [7:0] r, input logic [15:0] d);
        hpos           = 9'h100;
        vpos           = 9'h100;
        reg_address_in = r;
        data_in        = d;
        dma_ack        = 1'b0;
        #1;
        check("cpu_wr", 1'b0, 20'h0, NONE);
        @(negedge clk);
        reg_address_in = NONE;
        data_in        = 16'h0000;
    endtask

    initial begin
        reset          = 1'b1;
        clk7_en        = 1'b1;
        hpos           = 9'd0;
        vpos           = 9'd0;
        vbl_end        = 1'b0;
        spr_dma_en     = 1'b1;
        reg_address_in = NONE;
        data_in        = 16'h0000;
        dma_ack        = 1'b0;
        for (int i = 0; i < 8; i++) ptr_m[i] = 20'h0;

        // Reset cycle: sprite 0 slot with grant must stay silent.
        @(negedge clk);
        hpos    = SB;
        dma_ack = 1'b1;
        #1;
        check("reset", 1'b0, 20'h0, NONE);
        @(negedge clk);
        reset   = 1'b0;
        dma_ack = 1'b0;

        // A full idle frame: every sprite IDLE, no requests.
        for (int v = 0; v < 312; v++) run_line(9'(v), 1'b0, "idle_frame");

        // Pointers: sprite 0 = 0x09000, sprite n = 0x01000*n.
        cpu_wr(PTH0, 16'h0001);
        cpu_wr(PTL0, 16'h2000);
        ptr_m[0] = 20'h09000;
        for (int n = 1; n < 8; n++) begin
            cpu_wr(8'(145 + 2 * n), 16'(n * 16'h2000));
            ptr_m[n] = 20'(n * 20'h01000);
        end

        // vbl_end line: sprite 0 -> 0x30..0x32, sprite 5 zero height at 0x40,
        // sprite 3 gets no grant, others park with 0/0.
        for (int n = 0; n < 8; n++) begin
            if (n == 0)      push_pc(n, 1'b1, 1'b1, 16'h3000, 16'h3200);
            else if (n == 5) push_pc(n, 1'b1, 1'b1, 16'h4000, 16'h4000);
            else if (n == 3) push_pc(n, 1'b0, 1'b0, 16'h1111, 16'h2222);
            else             push_pc(n, 1'b1, 1'b1, 16'h0000, 16'h0000);
        end
        run_line(9'h01A, 1'b1, "vbl_pc");

        // Sprite 3 refetches from the unchanged pointer; nobody else requests.
        push_pc(3, 1'b1, 1'b1, 16'h0000, 16'h0000);
        run_line(9'h01B, 1'b0, "spr3_retry");
        run_line(9'h01C, 1'b0, "wait_idle");
        run_line(9'h02F, 1'b0, "pre_start");

        // Sprite 0 active on 0x30/0x31.
        push_data(0);
        run_line(9'h030, 1'b0, "data_l30");

        // Line 0x31: CPU PTL write coincides with the acked DATB fetch.
        push_ev(SB, 1'b1, 16'h4000, PTL0, ptr_m[0], POS0 + 8'd3);
        ptr_m[0] = {ptr_m[0][19:15], 15'h2000};
        push_ev(SB + 9'd2, 1'b1, 16'h5A5A, NONE, ptr_m[0], POS0 + 8'd2);
        ptr_m[0] = ptr_m[0] + 20'd1;
        run_line(9'h031, 1'b0, "data_l31_ptl");

        // vstop line: next control words (vstart 0x50, vstop 0x60).
        push_pc(0, 1'b1, 1'b1, 16'h5000, 16'h6000);
        run_line(9'h032, 1'b0, "vstop_pc");
        run_line(9'h033, 1'b0, "post_stop");

        // Zero-height sprite 5: control fetch on 0x40, no data.
        run_line(9'h03F, 1'b0, "pre_zero");
        push_pc(5, 1'b1, 1'b1, 16'h0000, 16'h0000);
        run_line(9'h040, 1'b0, "zero_height");
        run_line(9'h041, 1'b0, "after_zero");

        // DMA disabled: vbl_end ignored, states frozen.
        spr_dma_en = 1'b0;
        run_line(9'h050, 1'b1, "dma_off");
        spr_dma_en = 1'b1;
        run_line(9'h051, 1'b0, "resume");

        // vbl_end on sprite 0's vstart line: FETCH_PC wins over ACTIVE.
        for (int n = 0; n < 8; n++) push_pc(n, 1'b1, 1'b1, 16'h0000, 16'h0000);
        run_line(9'h050, 1'b1, "vbl_priority");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
